fifo_wr_ctrl: RTL and testbench

// - Write-side control of the async FIFO, in the write clock domain; counterpart of the read-side pointer/empty logic.
// - Keeps the binary write counter and addresses the dual-port memory.
// - Publishes a registered Gray write pointer for synchronisation into the read domain.
// - Derives full, almost-full and fill level from the Gray read pointer after it has been 2-flop synchronised into this domain.

---
 rtl/fifo_wr_ctrl.sv | 84 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-clock-domain side of the async FIFO.
// Owns the binary write counter, drives the memory write port, publishes the
// registered Gray write pointer, and derives full / almost-full / fill level
// from the read pointer already synchronised into wclk.
// Optional feature macro: WR_OVERFLOW_FLAG_EN adds the sticky woverflow output.
//
// Handshake: winc is a request (valid) and ~wfull is the ready. A write is
// accepted, and memory written at waddr, exactly on a wclk edge where
// wclken = winc & ~wfull is 1. A request while full is not accepted and is
// not retried by this block.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wclken,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel
`ifdef WR_OVERFLOW_FLAG_EN
  ,
  output logic                  woverflow
`endif
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rbin_s;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] full_gray;

  // Write strobe and next-state arithmetic, all from current state and inputs.
  always_comb begin
    wclken     = winc & ~wfull;
    wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wclken};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_gray  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    rbin_s     = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
    level_next = wbin_next - rbin_s;
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Pointer, flag and level registers; reset wins over any write request.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (level_next >= AFULL_LVL);
      wlevel       <= level_next;
    end
  end

`ifdef WR_OVERFLOW_FLAG_EN
  // Sticky record of any request made while full; only reset clears it.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      woverflow <= 1'b0;
    end else if (winc & wfull) begin
      woverflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus randomized traffic, checked
// against a counting model (total writes accepted, read count, level = difference).
module tb_fifo_wr_ctrl;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          wclk = 1'b0;
  logic          wrst;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   wptr;
  logic [AW-1:0] waddr;
  logic          wclken;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
`ifdef WR_OVERFLOW_FLAG_EN
  logic          woverflow;
`endif

  always #5 wclk = ~wclk;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .wclk(wclk),
    .wrst(wrst),
    .winc(winc),
    .wq2_rptr(wq2_rptr),
    .wptr(wptr),
    .waddr(waddr),
    .wclken(wclken),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wlevel(wlevel)
`ifdef WR_OVERFLOW_FLAG_EN
    ,
    .woverflow(woverflow)
`endif
  );

  // ---------------- model / scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int m_wr = 0;          // total writes accepted since reset
  int m_rd = 0;          // read count represented by wq2_rptr
  int m_lvl = 0;
  bit m_full = 1'b0;
  bit m_af = 1'b0;
  bit m_ovf = 1'b0;
  bit exp_wclken;
  logic seen_wclken;
  logic [AW:0] exp_q[$];

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  // {wptr, waddr, wlevel, wfull, walmost_full}
  function automatic logic [12:0] exp_vec();
    logic [AW:0] lv;
    logic [AW-1:0] ad;
    lv = m_lvl[AW:0];
    ad = m_wr[AW-1:0];
    return {to_gray(m_wr), ad, lv, m_full, m_af};
  endfunction

  function automatic logic [12:0] act_vec();
    return {wptr, waddr, wlevel, wfull, walmost_full};
  endfunction

  // ---------------- driver: one wclk cycle, model advanced at the edge ----------------
  task automatic cyc(input bit rst_i, input bit inc_i, input int rd_i);
    @(negedge wclk);
    wrst = rst_i;
    winc = inc_i;
    m_rd = rd_i;
    wq2_rptr = to_gray(rd_i);
    #1;
    seen_wclken = wclken;
    exp_wclken = inc_i && !m_full;
    @(posedge wclk);
    if (rst_i) begin
      m_wr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (inc_i && m_full) m_ovf = 1;
      if (inc_i && !m_full) m_wr++;
      m_lvl = m_wr - m_rd;
      m_full = (m_lvl == DEPTH);
      m_af = (m_lvl >= AF);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    checks++;
    if (seen_wclken !== 1'b1) begin
      errors++; $display("FAIL reset_wclken got %b want 1", seen_wclken);
    end
    checks++;
    if (act_vec() !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", act_vec());
    end
`ifdef WR_OVERFLOW_FLAG_EN
    checks++;
    if (woverflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", woverflow);
    end
`endif
  endtask

  task automatic test_fill();
    logic [AW:0] e;
    exp_q = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (waddr !== 3'(i - 1)) begin
        errors++; $display("FAIL fill_waddr step %0d got %0d want %0d", i, waddr, i - 1);
      end
      cyc(0, 1, 0);
      e = exp_q.pop_front();
      checks++;
      if (wptr !== e) begin
        errors++; $display("FAIL fill_wptr step %0d got %b want %b", i, wptr, e);
      end
      checks++;
      if (walmost_full !== (i >= AF) || wfull !== (i == DEPTH) || wlevel !== 4'(i)) begin
        errors++; $display("FAIL fill_flags step %0d got af=%b full=%b lvl=%0d want af=%b full=%b lvl=%0d",
                           i, walmost_full, wfull, wlevel, i >= AF, i == DEPTH, i);
      end
    end
  endtask

  task automatic test_write_full();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      checks++;
      if (seen_wclken !== 1'b0 || wptr !== 4'b1100 || waddr !== 3'd0 || wlevel !== 4'd8 || wfull !== 1'b1) begin
        errors++; $display("FAIL write_full got en=%b wptr=%b waddr=%0d lvl=%0d full=%b want en=0 wptr=1100 waddr=0 lvl=8 full=1",
                           seen_wclken, wptr, waddr, wlevel, wfull);
      end
`ifdef WR_OVERFLOW_FLAG_EN
      checks++;
      if (woverflow !== 1'b1) begin
        errors++; $display("FAIL overflow_set got %b want 1", woverflow);
      end
`endif
    end
  endtask

  task automatic test_drain();
    cyc(0, 0, 1);
    checks++;
    if (wfull !== 1'b0 || wlevel !== 4'd7 || walmost_full !== 1'b1) begin
      errors++; $display("FAIL drain got full=%b lvl=%0d af=%b want full=0 lvl=7 af=1", wfull, wlevel, walmost_full);
    end
    cyc(0, 1, 1);
    checks++;
    if (wfull !== 1'b1 || wlevel !== 4'd8 || waddr !== 3'd1) begin
      errors++; $display("FAIL refill got full=%b lvl=%0d waddr=%0d want full=1 lvl=8 waddr=1", wfull, wlevel, waddr);
    end
`ifdef WR_OVERFLOW_FLAG_EN
    checks++;
    if (woverflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky got %b want 1", woverflow);
    end
`endif
  endtask

  task automatic test_wrap();
    bit saw_wrap;
    logic [AW:0] prev;
    saw_wrap = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      prev = wptr;
      cyc(0, 1, m_rd + 1);
      if (prev === 4'b1000 && wptr === 4'b0000) saw_wrap = 1;
      checks++;
      if (wlevel !== 4'd4 || wfull !== 1'b0 || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap step %0d got %h want %h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_seen got %b want 1", saw_wrap);
    end
  endtask

  task automatic test_random();
    int room;
    int step;
    cyc(1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      room = m_wr - m_rd;
      step = (room > 3) ? 3 : room;
      // Reads lag behind writes so the FIFO regularly fills and overflows.
      cyc(0, 1'($urandom_range(0, 3) != 0), m_rd + (($urandom_range(0, 2) == 0) ? $urandom_range(0, step) : 0));
      checks++;
      if (seen_wclken !== exp_wclken) begin
        errors++; $display("FAIL rand_wclken step %0d got %b want %b", i, seen_wclken, exp_wclken);
      end
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_state step %0d got %h want %h", i, act_vec(), exp_vec());
      end
`ifdef WR_OVERFLOW_FLAG_EN
      checks++;
      if (woverflow !== m_ovf) begin
        errors++; $display("FAIL rand_ovf step %0d got %b want %b", i, woverflow, m_ovf);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    checks++;
    if (wlevel !== 4'd5) begin
      errors++; $display("FAIL mid_level got %0d want 5", wlevel);
    end
    cyc(1, 1, 0);
    checks++;
    if (act_vec() !== 13'd0) begin
      errors++; $display("FAIL mid_reset got %h want 0", act_vec());
    end
    cyc(0, 0, 0);
    checks++;
    if (act_vec() !== 13'd0) begin
      errors++; $display("FAIL mid_after got %h want 0", act_vec());
    end
`ifdef WR_OVERFLOW_FLAG_EN
    checks++;
    if (woverflow !== 1'b0) begin
      errors++; $display("FAIL mid_ovf got %b want 0", woverflow);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    wrst = 1'b1;
    winc = 1'b0;
    wq2_rptr = '0;
    test_reset();
    test_fill();
    test_write_full();
    test_drain();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
